imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side counterpart to the CPU's instruction fetch.
- Accepts a byte stream over a valid/ready handshake and assembles 16-bit instructions.
- Writes those instructions sequentially into instruction memory from address 0.
- Holds the CPU (cpu_hold) while a load is in progress, and releases it only after a correct checksum.

Parameters:
- ADDR_W, 8, instruction memory address width (matches 8-bit PC).
- INSTR_W, 16, instruction width; fixed at 2 bytes per word.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load when in IDLE, DONE or ERR.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader can accept a byte this cycle.
- mem_we  out  1  instruction memory write strobe, one cycle per word.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  INSTR_W  instruction word.
- cpu_hold  out  1  high while loading or after a failed load.
- busy  out  1  high in any state other than IDLE, DONE, ERR.
- done  out  1  one-cycle pulse on successful load.
- err  out  1  sticky checksum-failure flag.
- words_loaded  out  ADDR_W+1  count of words written in the current/last load.

Behaviour:
- Reset (synchronous):
  - state=IDLE.
  - in_ready, mem_we, busy, done, err, cpu_hold = 0.
  - mem_addr=0, mem_wdata=0, words_loaded=0, internal checksum=0.
- A byte transfers on a rising edge with in_valid && in_ready. in_ready is a registered function of state only; it does not depend on in_valid.
- Stream format:
  - Byte 0 is the word count N; value 0 means 256.
  - Then N words, high byte first.
  - Then one checksum byte equal to the XOR of all 2N instruction bytes.
- States:
  - IDLE: in_ready=0. start -> COUNT, sets cpu_hold=1, clears err, words_loaded, checksum and mem_addr.
  - COUNT: in_ready=1. Accept byte -> latch N -> HI.
  - HI: in_ready=1. Accept -> mem_wdata[15:8]=byte, checksum^=byte -> LO.
  - LO: in_ready=1. Accept -> mem_wdata[7:0]=byte, checksum^=byte -> WRITE.
  - WRITE:
    - in_ready=0, mem_we=1 for exactly this cycle, with mem_addr and mem_wdata stable.
    - Next cycle: mem_addr+=1 and words_loaded+=1.
    - If words_loaded+1==N -> CHECK, else -> HI.
  - CHECK: in_ready=1. Accept byte.
    - If byte==checksum -> DONE: done=1 for one cycle, cpu_hold=0.
    - Otherwise -> ERR: err=1, cpu_hold stays 1.
  - DONE/ERR: in_ready=0. start -> COUNT as from IDLE. err clears only on start or RESET.
- Latency:
  - mem_we asserts in the cycle after the LO byte is accepted.
  - Minimum word period is 3 cycles (HI, LO, WRITE).
- Boundary conditions:
  - N=0 (256 words): last write at mem_addr=255. mem_addr is then incremented to 0, which is don't-care because the state is CHECK. words_loaded=256 needs the ADDR_W+1 width.
  - start while busy: ignored, no state change.
  - in_valid low in any accepting state: stall indefinitely, outputs hold.
  - RESET mid-load: immediate return to reset values, including cpu_hold=0. Memory contents written so far are not reverted.
  - in_valid while in_ready=0: byte is not consumed; the source must hold it.

Decomposition:
- Shared cpu package holds:
  - state encoding constants (IDLE, COUNT, HI, LO, WRITE, CHECK, DONE, ERR; 3 bits).
  - ADDR_W/INSTR_W constants shared with the CPU.
- One natural sub-module: loader_byte_rx. It encapsulates the valid/ready handshake and the byte-accept pulse consumed by the FSM.
- Checksum and address counters stay in the top.

Test Plan:
- Load N=2, bytes 0x12,0x34,0xAB,0xCD, checksum 0x12^0x34^0xAB^0xCD=0x40 -> mem_we writes 0x1234@0 then 0xABCD@1; done pulses once; cpu_hold falls; err=0; words_loaded=2.
- Same stream with checksum 0x41 -> both words written, err=1, cpu_hold stays 1, done never pulses. Then start plus a good stream -> err clears, done pulses.
- N=0 with 256 words of data (word k = {k, ~k}) and a correct checksum -> 256 writes, last at address 0xFF, words_loaded=256, done pulses.
- Random in_valid gaps (about 50% duty) during the N=3 load -> identical memory contents; mem_we count=3; no byte lost or duplicated.
- start pulsed mid-load in state HI -> ignored, load completes normally.
- RESET asserted in state LO -> next cycle all outputs at reset values; a following start plus an N=1 load succeeds, with its word written at address 0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: constants and types shared by the instruction-memory loader
// and the CPU.
//   LD_ADDR_W  : instruction memory address width (matches the 8-bit PC)
//   LD_INSTR_W : instruction width, always two stream bytes per word
//   state_t    : loader FSM state encoding (3 bits)
package imem_loader_pkg;

  localparam int LD_ADDR_W  = 8;
  localparam int LD_INSTR_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_HI    = 3'd2,
    ST_LO    = 3'd3,
    ST_WRITE = 3'd4,
    ST_CHECK = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERR   = 3'd7
  } state_t;

  // Running stream checksum: XOR of every instruction byte.
  function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] b);
    return chk ^ b;
  endfunction

  // States in which a stream byte may be consumed.
  function automatic logic is_accepting(input state_t st);
    return (st == ST_COUNT) || (st == ST_HI) || (st == ST_LO) || (st == ST_CHECK);
  endfunction

  // States in which the loader is at rest and start is honoured.
  function automatic logic is_resting(input state_t st);
    return (st == ST_IDLE) || (st == ST_DONE) || (st == ST_ERR);
  endfunction

endpackage

// File: rtl/imem_loader_byte_rx.sv
// imem_loader_byte_rx: valid/ready front end of the loader.
//   CLK, RESET  : clock, synchronous active-high reset
//   ready_next  : loader will be able to take a byte in the next cycle
//   in_data     : stream byte from the source
//   in_valid    : source has a byte
//   in_ready    : registered ready, depends only on loader state
//   accept      : a byte transfers on this rising edge
//   rx_byte     : the byte being transferred
module imem_loader_byte_rx (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ready_next,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       accept,
  output logic [7:0] rx_byte
);

  // Ready register: loaded from the FSM's next state so it always matches the current state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      in_ready <= 1'b0;
    end else begin
      in_ready <= ready_next;
    end
  end

  assign accept  = in_valid & in_ready;
  assign rx_byte = in_data;

endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a byte stream (count, words high byte first, XOR
// checksum) and writes the words into instruction memory from address 0,
// holding the CPU until a load completes with a matching checksum.
//   CLK, RESET          : clock, synchronous active-high reset
//   start               : begin a load (honoured in IDLE, DONE, ERR)
//   in_data/in_valid/in_ready : byte stream handshake
//   mem_we/mem_addr/mem_wdata : instruction memory write port
//   cpu_hold            : CPU held while loading or after a failed load
//   busy                : load in progress
//   done                : one-cycle pulse on a successful load
//   err                 : sticky checksum failure
//   words_loaded        : words written in the current/last load
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W  = LD_ADDR_W,
  parameter int INSTR_W = LD_INSTR_W
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               start,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               cpu_hold,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [ADDR_W:0]    words_loaded
);

  state_t            state_r;
  state_t            state_s;
  logic [7:0]        count_r;
  logic [7:0]        chk_r;
  logic              accept_s;
  logic [7:0]        rx_byte_s;
  logic [ADDR_W:0]   n_total_s;
  logic              last_word_s;

  imem_loader_byte_rx u_rx (
    .CLK        (CLK),
    .RESET      (RESET),
    .ready_next (is_accepting(state_s)),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .accept     (accept_s),
    .rx_byte    (rx_byte_s)
  );

  // A count byte of zero stands for the full 2^ADDR_W words.
  assign n_total_s   = (count_r == 8'd0) ? {1'b1, {ADDR_W{1'b0}}} : (ADDR_W+1)'(count_r);
  assign last_word_s = ((words_loaded + (ADDR_W+1)'(1'b1)) == n_total_s);

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) state_s = ST_COUNT;
        else       state_s = state_r;
      end
      ST_COUNT: begin
        if (accept_s) state_s = ST_HI;
        else          state_s = state_r;
      end
      ST_HI: begin
        if (accept_s) state_s = ST_LO;
        else          state_s = state_r;
      end
      ST_LO: begin
        if (accept_s) state_s = ST_WRITE;
        else          state_s = state_r;
      end
      ST_WRITE: begin
        if (last_word_s) state_s = ST_CHECK;
        else             state_s = ST_HI;
      end
      ST_CHECK: begin
        if (!accept_s)               state_s = state_r;
        else if (rx_byte_s == chk_r) state_s = ST_DONE;
        else                         state_s = ST_ERR;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r      <= ST_IDLE;
      count_r      <= 8'd0;
      chk_r        <= 8'd0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_hold     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      state_r <= state_s;
      mem_we  <= (state_s == ST_WRITE);
      busy    <= !is_resting(state_s);
      done    <= (state_r == ST_CHECK) && (state_s == ST_DONE);
      case (state_r)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            cpu_hold     <= 1'b1;
            err          <= 1'b0;
            words_loaded <= '0;
            chk_r        <= 8'd0;
            mem_addr     <= '0;
          end
        end
        ST_COUNT: begin
          if (accept_s) count_r <= rx_byte_s;
        end
        ST_HI: begin
          if (accept_s) begin
            mem_wdata[INSTR_W-1 -: 8] <= rx_byte_s;
            chk_r                     <= chk_update(chk_r, rx_byte_s);
          end
        end
        ST_LO: begin
          if (accept_s) begin
            mem_wdata[7:0] <= rx_byte_s;
            chk_r          <= chk_update(chk_r, rx_byte_s);
          end
        end
        ST_WRITE: begin
          // Address wraps to 0 after the 256th word; harmless, the FSM is in CHECK.
          mem_addr     <= mem_addr + ADDR_W'(1'b1);
          words_loaded <= words_loaded + (ADDR_W+1)'(1'b1);
        end
        ST_CHECK: begin
          if (accept_s) begin
            if (rx_byte_s == chk_r) cpu_hold <= 1'b0;
            else                    err      <= 1'b1;
          end
        end
        default: begin
          cpu_hold <= cpu_hold;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed sequence of loads with randomized data and
// handshake gaps, checked against a stream-level model of the loader.
module tb_imem_loader;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [8:0]  words_loaded;

  int vectors     = 0;
  int miscompares = 0;

  int          wr_cnt   = 0;
  int          done_cnt = 0;
  logic [7:0]  wlog_addr [0:1023];
  logic [15:0] wlog_data [0:1023];

  imem_loader dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 CLK = ~CLK;

  // Log every memory write and done pulse away from the rising edge.
  always @(negedge CLK) begin
    if (mem_we) begin
      if (wr_cnt < 1024) begin
        wlog_addr[wr_cnt] = mem_addr;
        wlog_data[wr_cnt] = mem_wdata;
      end
      wr_cnt++;
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one byte; optional random idle cycles first. Returns at the
  // falling edge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input bit gappy);
    int budget;
    budget = 0;
    if (gappy) begin
      while ($urandom_range(1, 0) == 1) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(negedge CLK);
      end
    end
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && budget < 20) begin
      @(negedge CLK);
      budget++;
    end
    if (!in_ready) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  // mode 0: random words, 1: {1234,ABCD}, 2: word k = {k, ~k}
  task automatic run_load(input int n_byte, input int mode, input bit bad,
                          input bit gappy, input bit start_mid);
    int          n_eff;
    int          wr0;
    int          dn0;
    logic [15:0] words [$];
    logic [15:0] w;
    logic [7:0]  kb;
    logic [7:0]  cks;
    logic [7:0]  nb;
    n_eff = (n_byte == 0) ? 256 : n_byte;
    nb    = n_byte[7:0];
    cks   = 8'h00;
    for (int k = 0; k < n_eff; k++) begin
      kb = k[7:0];
      case (mode)
        1:       w = (k == 0) ? 16'h1234 : 16'hABCD;
        2:       w = {kb, ~kb};
        default: w = 16'($urandom);
      endcase
      words.push_back(w);
      cks = cks ^ w[15:8] ^ w[7:0];
    end
    if (bad) cks = cks ^ 8'h01;
    wr0 = wr_cnt;
    dn0 = done_cnt;

    pulse_start();
    chk("hold_at_start", {31'd0, cpu_hold}, 32'd1);
    chk("busy_at_start", {31'd0, busy}, 32'd1);
    chk("err_cleared",   {31'd0, err}, 32'd0);

    send_byte(nb, gappy);
    for (int k = 0; k < n_eff; k++) begin
      if (k == 0 && start_mid) pulse_start();
      send_byte(words[k][15:8], gappy);
      send_byte(words[k][7:0], gappy);
    end
    send_byte(cks, gappy);
    repeat (2) @(negedge CLK);

    chk("write_count", wr_cnt - wr0, n_eff);
    for (int k = 0; k < n_eff && (wr0 + k) < wr_cnt && (wr0 + k) < 1024; k++) begin
      kb = k[7:0];
      chk("write_addr", {24'd0, wlog_addr[wr0 + k]}, {24'd0, kb});
      chk("write_data", {16'd0, wlog_data[wr0 + k]}, {16'd0, words[k]});
    end
    chk("done_pulses",  done_cnt - dn0, bad ? 0 : 1);
    chk("err_flag",     {31'd0, err}, {31'd0, bad});
    chk("cpu_hold_end", {31'd0, cpu_hold}, {31'd0, bad});
    chk("words_loaded", {23'd0, words_loaded}, n_eff);
    chk("busy_end",     {31'd0, busy}, 32'd0);
  endtask

  initial begin
    RESET    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge CLK);

    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_mem_we",   {31'd0, mem_we}, 32'd0);
    chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    chk("rst_addr",     {24'd0, mem_addr}, 32'd0);
    chk("rst_words",    {23'd0, words_loaded}, 32'd0);
    RESET = 1'b0;
    @(negedge CLK);
    chk("idle_ready",   {31'd0, in_ready}, 32'd0);

    // Basic good load, then bad checksum, then recovery.
    run_load(2, 1, 1'b0, 1'b0, 1'b0);
    run_load(2, 1, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge CLK);
    chk("err_sticky",   {31'd0, err}, 32'd1);
    run_load(2, 1, 1'b0, 1'b0, 1'b0);

    // Full 256-word load.
    run_load(0, 2, 1'b0, 1'b0, 1'b0);

    // Random data with handshake gaps.
    run_load(3, 0, 1'b0, 1'b1, 1'b0);
    run_load(3, 0, 1'b0, 1'b1, 1'b0);

    // Start while busy is ignored.
    run_load(3, 0, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a load (state LO).
    pulse_start();
    send_byte(8'd1, 1'b0);
    send_byte(8'h5A, 1'b0);
    RESET = 1'b1;
    @(negedge CLK);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("mid_rst_mem_we",   {31'd0, mem_we}, 32'd0);
    chk("mid_rst_busy",     {31'd0, busy}, 32'd0);
    chk("mid_rst_done",     {31'd0, done}, 32'd0);
    chk("mid_rst_err",      {31'd0, err}, 32'd0);
    chk("mid_rst_hold",     {31'd0, cpu_hold}, 32'd0);
    chk("mid_rst_addr",     {24'd0, mem_addr}, 32'd0);
    chk("mid_rst_wdata",    {16'd0, mem_wdata}, 32'd0);
    chk("mid_rst_words",    {23'd0, words_loaded}, 32'd0);
    RESET = 1'b0;
    @(negedge CLK);
    run_load(1, 0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
